// File: rtl/vend_credit_fsm.sv
// ---------------------------------------------------------------------------
// vend_credit_fsm
//   Vending credit controller. Takes the coin code from the switch encoder
//   plus a coin-present level, and turns each new press into one credit
//   increment. When the credit reaches PRICE it issues a one-cycle vend
//   pulse and then a one-cycle change strobe. A cancel with non-zero credit
//   refunds the credit through the same change strobe, without vending.
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   synchronous active-low reset
//   coin_valid    in   high while any coin switch is pressed
//   coin_code     in   [1:0] denomination, meaningful when coin_valid=1
//   cancel        in   level, requests a refund of the held credit
//   credit        out  [CW-1:0] accumulated credit (registered)
//   busy          out  high in VEND or CHANGE
//   vend          out  one-cycle dispense pulse
//   change_valid  out  one-cycle strobe qualifying change_amt
//   change_amt    out  [CW-1:0] change/refund, zero outside the strobe
// ---------------------------------------------------------------------------
module vend_credit_fsm #(
  parameter int unsigned PRICE = 65,
  parameter int unsigned CW    = 8,
  parameter int unsigned VAL0  = 5,
  parameter int unsigned VAL1  = 10,
  parameter int unsigned VAL2  = 25,
  parameter int unsigned VAL3  = 100
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          coin_valid,
  input  logic [1:0]    coin_code,
  input  logic          cancel,
  output logic [CW-1:0] credit,
  output logic          busy,
  output logic          vend,
  output logic          change_valid,
  output logic [CW-1:0] change_amt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_e;

  localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
  localparam logic [CW:0]   V0      = (CW+1)'(VAL0);
  localparam logic [CW:0]   V1      = (CW+1)'(VAL1);
  localparam logic [CW:0]   V2      = (CW+1)'(VAL2);
  localparam logic [CW:0]   V3      = (CW+1)'(VAL3);

  state_e        state_q;
  logic [CW-1:0] credit_q;
  logic          coin_prev_q;
  logic          vend_q;
  logic          busy_q;
  logic          chg_vld_q;
  logic [CW-1:0] chg_amt_q;

  logic          coin_evt;
  logic [CW:0]   coin_val;
  logic [CW:0]   credit_sum;
  logic [CW-1:0] credit_add_d;
  logic          below_price;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    coin_val = V0;
    case (coin_code)
      2'b00:   coin_val = V0;
      2'b01:   coin_val = V1;
      2'b10:   coin_val = V2;
      default: coin_val = V3;
    endcase
    coin_evt    = coin_valid & ~coin_prev_q;
    // One extra bit catches overflow; saturate to all-ones on carry out.
    credit_sum  = {1'b0, credit_q} + coin_val;
    credit_add_d = credit_sum[CW] ? {CW{1'b1}} : credit_sum[CW-1:0];
    below_price = (credit_q < PRICE_C);
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // right-hand side sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      credit_q    <= '0;
      coin_prev_q <= 1'b0;
      vend_q      <= 1'b0;
      busy_q      <= 1'b0;
      chg_vld_q   <= 1'b0;
      chg_amt_q   <= '0;
    end else begin
      // The edge detector runs in every state, so a press during VEND or
      // CHANGE is consumed and cannot fire later.
      coin_prev_q <= coin_valid;
      vend_q      <= 1'b0;
      chg_vld_q   <= 1'b0;

      case (state_q)
        IDLE, COLLECT: begin
          if (state_q == COLLECT && !below_price) begin
            // Price reached: this cycle accepts neither coins nor cancel.
            state_q <= VEND;
            vend_q  <= 1'b1;
            busy_q  <= 1'b1;
          end else if (cancel) begin
            // Cancel beats a simultaneous coin; with no credit it is a no-op.
            if (credit_q != '0) begin
              state_q   <= CHANGE;
              chg_vld_q <= 1'b1;
              chg_amt_q <= credit_q;
              busy_q    <= 1'b1;
            end
          end else if (coin_evt) begin
            credit_q <= credit_add_d;
            state_q  <= COLLECT;
          end
        end

        VEND: begin
          state_q   <= CHANGE;
          chg_vld_q <= 1'b1;
          chg_amt_q <= credit_q - PRICE_C;
        end

        CHANGE: begin
          state_q   <= IDLE;
          credit_q  <= '0;
          chg_amt_q <= '0;
          busy_q    <= 1'b0;
        end

        default: begin
          state_q   <= IDLE;
          credit_q  <= '0;
          chg_amt_q <= '0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign credit       = credit_q;
  assign busy         = busy_q;
  assign vend         = vend_q;
  assign change_valid = chg_vld_q;
  assign change_amt   = chg_amt_q;

endmodule

// File: tb/tb_vend_credit_fsm.sv
// ---------------------------------------------------------------------------
// tb_vend_credit_fsm
//   Directed bench for vend_credit_fsm with default parameters
//   (PRICE=65, coins 5/10/25/100). Inputs change 1 ns after a rising edge
//   and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_vend_credit_fsm;

  logic       clk;
  logic       rst_n;
  logic       coin_valid;
  logic [1:0] coin_code;
  logic       cancel;
  logic [7:0] credit;
  logic       busy;
  logic       vend;
  logic       change_valid;
  logic [7:0] change_amt;

  int total = 0;
  int bad   = 0;

  vend_credit_fsm dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coin_valid   (coin_valid),
    .coin_code    (coin_code),
    .cancel       (cancel),
    .credit       (credit),
    .busy         (busy),
    .vend         (vend),
    .change_valid (change_valid),
    .change_amt   (change_amt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full output snapshot against expected values.
  task automatic expect_out(input string tag, input logic [7:0] e_credit, input logic e_busy,
                            input logic e_vend, input logic e_cv, input logic [7:0] e_amt);
    check({tag, ".credit"}, {24'd0, credit}, {24'd0, e_credit});
    check({tag, ".busy"},   {31'd0, busy},   {31'd0, e_busy});
    check({tag, ".vend"},   {31'd0, vend},   {31'd0, e_vend});
    check({tag, ".cv"},     {31'd0, change_valid}, {31'd0, e_cv});
    check({tag, ".amt"},    {24'd0, change_amt},   {24'd0, e_amt});
  endtask

  // Press for one edge (the event edge), then release for one edge.
  task automatic press(input logic [1:0] code);
    coin_code  = code;
    coin_valid = 1'b1;
    tick();
  endtask

  task automatic release_coin();
    coin_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; coin_valid = 1'b0; coin_code = 2'b00; cancel = 1'b0;
    #1;

    // Reset with random coin/cancel activity
    for (int i = 0; i < 2; i++) begin
      coin_valid = 1'($urandom_range(0, 1));
      coin_code  = 2'($urandom_range(0, 3));
      cancel     = 1'($urandom_range(0, 1));
      tick();
    end
    coin_valid = 1'b0; cancel = 1'b0;
    tick();
    expect_out("reset", 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    tick();
    expect_out("idle", 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);

    // 25+25+10+5 = exact price, change 0
    press(2'b10);  check("c1.credit", {24'd0, credit}, 32'd25);
    release_coin();
    press(2'b10);  check("c2.credit", {24'd0, credit}, 32'd50);
    release_coin();
    press(2'b01);  check("c3.credit", {24'd0, credit}, 32'd60);
    release_coin();
    press(2'b00);  expect_out("c4", 8'd65, 1'b0, 1'b0, 1'b0, 8'd0);
    coin_valid = 1'b0;
    tick();        expect_out("exact.vend", 8'd65, 1'b1, 1'b1, 1'b0, 8'd0);
    tick();        expect_out("exact.chg", 8'd65, 1'b1, 1'b0, 1'b1, 8'd0);
    tick();        expect_out("exact.idle", 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Single 100 coin -> change 35
    press(2'b11);  expect_out("d1", 8'd100, 1'b0, 1'b0, 1'b0, 8'd0);
    release_coin(); expect_out("d1.vend", 8'd100, 1'b1, 1'b1, 1'b0, 8'd0);
    tick();        expect_out("d1.chg", 8'd100, 1'b1, 1'b0, 1'b1, 8'd35);
    tick();        expect_out("d1.idle", 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Held switch counts once; re-press counts again
    coin_code = 2'b01; coin_valid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("hold.credit", {24'd0, credit}, 32'd10);
    release_coin(); check("hold.rel", {24'd0, credit}, 32'd10);
    press(2'b01);   check("hold.repress", {24'd0, credit}, 32'd20);
    release_coin();
    cancel = 1'b1;
    tick();        expect_out("hold.cancel", 8'd20, 1'b1, 1'b0, 1'b1, 8'd20);
    cancel = 1'b0;
    tick();        expect_out("hold.idle", 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Cancel refund of 25, then cancel with zero credit
    press(2'b10);  check("can.credit", {24'd0, credit}, 32'd25);
    release_coin();
    cancel = 1'b1;
    tick();        expect_out("can.chg", 8'd25, 1'b1, 1'b0, 1'b1, 8'd25);
    cancel = 1'b0;
    tick();        expect_out("can.idle", 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    cancel = 1'b1;
    tick();        expect_out("can0.a", 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    tick();        expect_out("can0.b", 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    cancel = 1'b0;

    // Cancel and coin edge together at credit 10: cancel wins
    press(2'b01);  check("cc.credit", {24'd0, credit}, 32'd10);
    release_coin();
    coin_code = 2'b10; coin_valid = 1'b1; cancel = 1'b1;
    tick();        expect_out("cc.chg", 8'd10, 1'b1, 1'b0, 1'b1, 8'd10);
    coin_valid = 1'b0; cancel = 1'b0;
    tick();        expect_out("cc.idle", 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Coin edge during VEND is discarded
    press(2'b11);
    release_coin(); check("vc.vend", {31'd0, vend}, 32'd1);
    press(2'b00);   expect_out("vc.chg", 8'd100, 1'b1, 1'b0, 1'b1, 8'd35);
    coin_valid = 1'b0;
    tick();        expect_out("vc.idle", 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    tick();        check("vc.after", {24'd0, credit}, 32'd0);

    // Reset during VEND aborts with no change pulse
    press(2'b11);
    release_coin(); check("rv.vend", {31'd0, vend}, 32'd1);
    rst_n = 1'b0;
    tick();        expect_out("rv.rst", 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    tick();        expect_out("rv.post1", 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    tick();        expect_out("rv.post2", 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vend_credit_fsm.md
Name: vend_credit_fsm

Overview:
Sequential vending controller that consumes the 2-bit coin code from the 4-to-2 switch encoder, together with a coin-present level, and accumulates credit. When credit reaches PRICE it issues a one-cycle vend pulse, then reports change. A cancel input returns the held credit without vending. Sits directly downstream of the encoder and drives the dispense/change/display logic.

Parameters:
PRICE, 65, item price in cents; must be in 1..2^CW-1
CW, 8, credit/change width in bits
VAL0, 5, cents for coin_code 2'b00
VAL1, 10, cents for coin_code 2'b01
VAL2, 25, cents for coin_code 2'b10
VAL3, 100, cents for coin_code 2'b11

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
coin_valid  input  1  level, high while any coin switch is pressed (OR of the encoder's inputs)
coin_code  input  2  encoded denomination, meaningful only when coin_valid=1
cancel  input  1  level, request refund of held credit
credit  output  CW  current accumulated credit, registered
busy  output  1  high in VEND or CHANGE state
vend  output  1  one-cycle dispense pulse
change_valid  output  1  one-cycle strobe, change_amt valid
change_amt  output  CW  change/refund in cents; 0 whenever change_valid=0

Behaviour:
- One clock, clk. Reset is synchronous and active-low via rst_n. All outputs are registered or Moore-decoded from registered state.
- Reset (rst_n=0 at a rising edge): state=IDLE, credit=0, vend=0, change_valid=0, change_amt=0, busy=0, coin_prev=0. Reset mid-VEND or mid-CHANGE aborts with no vend and no change pulse.
- Edge detect: coin_prev<=coin_valid every cycle, in every state. coin_evt = coin_valid & ~coin_prev. A held switch yields exactly one event. Events are never queued.
- States:
  - IDLE: credit=0.
  - COLLECT: 0<credit<PRICE before the update check.
  - VEND
  - CHANGE
- Coin acceptance: only in IDLE, or in COLLECT with credit<PRICE.
  - credit <= min(credit + VALn, 2^CW-1), saturating, computed in CW+1 bits.
  - Next state is COLLECT.
  - Events in VEND or CHANGE are discarded. The edge is still consumed.
- COLLECT with credit>=PRICE: next state VEND. No coin or cancel is accepted that cycle.
- VEND: vend=1 for exactly this one cycle. Next state CHANGE with change_amt<=credit-PRICE.
- CHANGE: change_valid=1 for one cycle with the registered change_amt. change_valid=1 even when the amount is 0. Next cycle: state=IDLE, credit=0, change_amt=0.
- Cancel: evaluated in IDLE or COLLECT with credit<PRICE.
  - If credit>0: next state CHANGE with change_amt<=credit, and vend never asserts.
  - If credit==0: no effect.
  - Cancel and coin_evt in the same cycle: cancel wins and the coin is discarded.
- Latency for a coin completing the price:
  - Event sampled at edge N.
  - Credit updated after edge N; state COLLECT.
  - VEND (vend=1) after edge N+1.
  - CHANGE (change_valid=1) after edge N+2.
  - IDLE with credit=0 after edge N+3.
- Cancel latency: CHANGE one cycle after the sampling edge, IDLE the cycle after.
- busy=1 exactly in VEND and CHANGE.

Test Plan:
- rst_n=0 for 2 cycles with random coin/cancel activity -> credit=0, vend=0, change_valid=0, change_amt=0, busy=0, state IDLE.
- Pulse coins code 10,10,01,00 (25+25+10+5) -> credit 25,50,60,65. Then vend=1 for one cycle, 2 cycles after the last edge. Then change_valid=1 with change_amt=0. Then credit=0.
- Single coin code 11 -> credit=100, vend pulse, change_valid=1 with change_amt=35, return to IDLE after 4 cycles total.
- Hold coin_valid=1 with code 01 for 10 cycles -> credit=10 exactly. Release and re-press -> credit=20.
- Coin 10 (credit 25), then cancel=1 -> change_valid=1, change_amt=25, vend never asserts, credit=0. Cancel with credit=0 -> no outputs change.
- Cancel and a coin edge in the same cycle at credit=10 -> refund 10, no credit added. A coin edge during VEND -> ignored, credit=0 afterwards. rst_n=0 during VEND -> no change_valid pulse, all outputs 0.
